// File: rtl/bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter
//   Iterative binary-to-BCD converter (shift-add-3 / double dabble).
//   One input bit is consumed per clock, MSB first, so a conversion takes
//   BIN_W cycles from the accepting edge to the done pulse.
//
// Ports
//   i_clk       : clock, rising edge active
//   i_rst_n     : asynchronous active-low reset
//   i_start     : conversion request, accepted only while idle
//   i_bin_in    : unsigned binary value, sampled at the accepting edge
//   o_busy      : high while a conversion is in flight
//   o_done      : one-cycle pulse, new digits valid
//   o_hundreds  : BCD hundreds digit of the last completed conversion
//   o_tens      : BCD tens digit of the last completed conversion
//   o_ones      : BCD ones digit of the last completed conversion
//
// state | meaning
// IDLE  | waiting for start, digits hold last result
// SHIFT | one add-3/shift step per clock, r_cnt steps remaining
// ---------------------------------------------------------------------------
module bcd_converter #(
  parameter int BIN_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_hundreds,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] r_shift;
  logic [11:0]      r_scratch;
  logic [3:0]       r_cnt;
  logic             r_done;
  logic [3:0]       r_hundreds;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;

  logic             w_accept;
  logic             w_last;
  logic [11:0]      w_adj;
  logic [11:0]      w_scratch_nxt;

  // Next-state / control decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 4'd1) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add 3 to every digit >= 5 so the following left shift carries correctly
  // into the next decade.
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < 3; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
    w_scratch_nxt = {w_adj[10:0], r_shift[BIN_W-1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_hundreds <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift   <= i_bin_in;
        r_scratch <= '0;
        r_cnt     <= 4'(BIN_W);
      end else if (r_state == SHIFT) begin
        r_shift   <= r_shift << 1;
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt - 4'd1;
        if (w_last) begin
          // Digits are loaded only from the final step, never intermediates.
          r_hundreds <= w_scratch_nxt[11:8];
          r_tens     <= w_scratch_nxt[7:4];
          r_ones     <= w_scratch_nxt[3:0];
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = (r_state == SHIFT);
  assign o_done     = r_done;
  assign o_hundreds = r_hundreds;
  assign o_tens     = r_tens;
  assign o_ones     = r_ones;

endmodule

// File: tb/tb_bcd_converter.sv
module tb_bcd_converter;

  localparam int BIN_W = 7;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_expected = 0;

  logic [11:0] exp_q[$];

  bcd_converter #(.BIN_W(BIN_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_bin_in   (bin_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_hundreds (hundreds),
    .o_tens     (tens),
    .o_ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %0d/%0d/%0d, expected no done", hundreds, tens, ones);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({hundreds, tens, ones} !== e || busy !== 1'b0) begin
          errors++;
          $display("FAIL result: got %0d/%0d/%0d busy=%0b, expected %0d/%0d/%0d busy=0",
                   hundreds, tens, ones, busy, e[11:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  // Issue a request right after a rising edge; returns just after the edge
  // at which done rises (BIN_W edges after the accepting edge).
  task automatic convert(input int v, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    exp_q.push_back({h, t, o});
    n_expected++;
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (BIN_W) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BIN_W-1:0] q;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_digits", {hundreds, tens, ones}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero input
    convert(0, 4'd0, 4'd0, 4'd0);
    @(posedge clk); #1;

    // 127: busy for exactly BIN_W cycles, then done with busy low
    exp_q.push_back({4'd1, 4'd2, 4'd7});
    n_expected++;
    start  = 1'b1;
    bin_in = 7'd127;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < BIN_W; i++) begin
      @(negedge clk);
      check("busy_window", {busy, done}, 2'b10);
    end
    @(negedge clk);
    check("done_cycle", {busy, done}, 2'b01);
    @(negedge clk);
    check("done_single", done, 0);
    check("digits_hold", {hundreds, tens, ones}, 12'h127);

    // 99 with bin_in change and start pulses during busy
    @(posedge clk); #1;
    exp_q.push_back({4'd0, 4'd9, 4'd9});
    n_expected++;
    start  = 1'b1;
    bin_in = 7'd99;
    @(posedge clk); #1;
    bin_in = 7'd5;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (BIN_W + 3) @(posedge clk);
    #1;
    check("after_99", {hundreds, tens, ones}, 12'h099);

    // Back-to-back: 100 accepted in the done cycle of 42
    convert(42, 4'd0, 4'd4, 4'd2);
    check("b2b_first", {done, hundreds, tens, ones}, {1'b1, 12'h042});
    convert(100, 4'd1, 4'd0, 4'd0);
    check("b2b_second", {done, hundreds, tens, ones}, {1'b1, 12'h100});
    @(posedge clk); #1;

    // Reset mid-conversion of 85
    exp_q.push_back({4'd0, 4'd8, 4'd5});
    start  = 1'b1;
    bin_in = 7'd85;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_digits", {hundreds, tens, ones}, 0);
    check("abort_busy", {busy, done}, 0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (BIN_W + 2) @(posedge clk);
    #1;
    check("abort_no_done_digits", {hundreds, tens, ones}, 0);
    convert(85, 4'd0, 4'd8, 4'd5);

    // Sweep from a wrapping 7-bit counter, 0..127 then wrap to 0
    q = '0;
    for (int k = 0; k < 129; k++) begin
      convert(int'(q), 4'(int'(q) / 100), 4'((int'(q) / 10) % 10), 4'(int'(q) % 10));
      q = q + 1'b1;
    end

    repeat (BIN_W + 3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, n_expected);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
